// File: rtl/spi_ram_master_if.sv
// Host-side request/response bundle for spi_ram_master.
//   req_valid/req_ready  one-shot request handshake (accepted on valid && ready)
//   req_wr               1 = write, 0 = read
//   req_addr/req_wdata   RAM address and write data
//   rsp_valid/rsp_rdata  completion pulse and read data
//   busy                 sequencer is working on an accepted request
// Modports: master = host issuing requests, slave = the sequencer.
interface spi_ram_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// Host-side SPI master sequencer for an SPI slave fronting a single-port RAM.
// A write becomes an address frame then a data frame; a read becomes an address
// frame then a read-data frame. Address frames are skipped when the slave's
// matching address register is known to hold the requested address already.
// Ports:
//   clk, rst_n   shared system clock, asynchronous active-low reset
//   host         request/response bundle (spi_ram_master_if.slave)
//   SS_n, MOSI   slave select (active low) and serial data out, MSB first
//   MISO         serial data from the slave
module spi_ram_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_SKEW    = 1,
  parameter int GAP_CYCLES = 1,
  parameter int ADDR_CACHE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_master_if.slave host,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO
);

  // Frame = duplicated cmd[1], cmd[0], payload.
  localparam int FRM_W = ADDR_W + 3;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // Bit-counter values: counter equals k during frame cycle ck.
  localparam logic [4:0]       LAST_CMD_BIT = 5'(FRM_W);
  localparam logic [4:0]       RD_FIRST     = 5'(FRM_W + 1 + RD_SKEW);
  localparam logic [4:0]       RD_LAST      = 5'(FRM_W + DATA_W + RD_SKEW);
  localparam logic [GAP_W-1:0] GAP_LOAD     = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_FRM, S_GAP, S_DATA_FRM, S_RDAT_FRM, S_DONE
  } state_t;

  state_t            state_reg;
  logic [4:0]        bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [FRM_W-1:0]  shift_reg;
  logic [DATA_W-1:0] rx_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              data_next_reg;   // the running GAP precedes a data frame
  logic              wc_valid_reg, rc_valid_reg;
  logic [ADDR_W-1:0] wc_addr_reg, rc_addr_reg;
  logic              hit;

  function automatic logic [FRM_W-1:0] frame_word(input logic [1:0] cmd,
                                                  input logic [ADDR_W-1:0] payload);
    return {cmd[1], cmd[1], cmd[0], payload};
  endfunction

  // Cache hit for the request currently offered on the host bundle.
  always_comb begin
    hit = 1'b0;
    if (ADDR_CACHE != 0) begin
      if (host.req_wr) hit = wc_valid_reg && (wc_addr_reg == host.req_addr);
      else             hit = rc_valid_reg && (rc_addr_reg == host.req_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      shift_reg      <= '0;
      rx_reg         <= '0;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      data_next_reg  <= 1'b0;
      wc_valid_reg   <= 1'b0;
      rc_valid_reg   <= 1'b0;
      wc_addr_reg    <= '0;
      rc_addr_reg    <= '0;
      SS_n           <= 1'b1;
      MOSI           <= 1'b0;
      host.req_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      host.busy      <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (host.req_valid && host.req_ready) begin
            wr_reg         <= host.req_wr;
            addr_reg       <= host.req_addr;
            wdata_reg      <= host.req_wdata;
            host.req_ready <= 1'b0;
            host.busy      <= 1'b1;
            // First frame starts immediately: this edge produces c0.
            SS_n           <= 1'b0;
            MOSI           <= 1'b0;
            bit_cnt_reg    <= '0;
            if (hit) begin
              state_reg <= host.req_wr ? S_DATA_FRM : S_RDAT_FRM;
              shift_reg <= host.req_wr ? frame_word(CMD_WR_DATA, host.req_wdata)
                                       : frame_word(CMD_RD_DATA, '0);
            end else begin
              state_reg <= S_ADDR_FRM;
              shift_reg <= frame_word(host.req_wr ? CMD_WR_ADDR : CMD_RD_ADDR,
                                      host.req_addr);
            end
          end
        end

        S_ADDR_FRM, S_DATA_FRM: begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == LAST_CMD_BIT) begin
            SS_n          <= 1'b1;
            MOSI          <= 1'b0;
            gap_cnt_reg   <= GAP_LOAD;
            state_reg     <= S_GAP;
            data_next_reg <= (state_reg == S_ADDR_FRM);
            // The slave's address register now holds addr_reg.
            if (state_reg == S_ADDR_FRM) begin
              if (wr_reg) begin
                wc_valid_reg <= 1'b1;
                wc_addr_reg  <= addr_reg;
              end else begin
                rc_valid_reg <= 1'b1;
                rc_addr_reg  <= addr_reg;
              end
            end
          end else begin
            MOSI      <= shift_reg[FRM_W-1];
            shift_reg <= shift_reg << 1;
          end
        end

        S_RDAT_FRM: begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg < LAST_CMD_BIT) begin
            MOSI      <= shift_reg[FRM_W-1];
            shift_reg <= shift_reg << 1;
          end else begin
            MOSI <= 1'b0;
          end
          if (bit_cnt_reg >= RD_FIRST && bit_cnt_reg <= RD_LAST)
            rx_reg <= {rx_reg[DATA_W-2:0], MISO};
          if (bit_cnt_reg == RD_LAST) begin
            SS_n          <= 1'b1;
            gap_cnt_reg   <= GAP_LOAD;
            state_reg     <= S_GAP;
            data_next_reg <= 1'b0;
          end
        end

        S_GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end else if (data_next_reg) begin
            SS_n        <= 1'b0;
            MOSI        <= 1'b0;
            bit_cnt_reg <= '0;
            state_reg   <= wr_reg ? S_DATA_FRM : S_RDAT_FRM;
            shift_reg   <= wr_reg ? frame_word(CMD_WR_DATA, wdata_reg)
                                  : frame_word(CMD_RD_DATA, '0);
          end else begin
            state_reg      <= S_DONE;
            host.rsp_valid <= 1'b1;
            host.rsp_rdata <= wr_reg ? '0 : rx_reg;
            host.busy      <= 1'b0;
          end
        end

        S_DONE: begin
          // req_ready stays low here, so a request offered now waits for IDLE.
          state_reg      <= S_IDLE;
          host.req_ready <= 1'b1;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
